// File: rtl/find_min_n_vals_seq.sv
// ---------------------------------------------------------------------------
// find_min_n_vals_seq
//
// Collects a burst of N_VALS unsigned readings, one per value_valid cycle,
// and reports the smallest reading together with its 1-based position in
// the burst. A start/busy/done handshake frames each burst. This block sits
// between the range-sampling logic and the location/display logic.
//
// Optional feature (compile-time macro FIND_MIN_IGNORE_ZERO_EN):
//   When defined, a reading of 0 (no echo) still counts toward the burst
//   length but never becomes the minimum. An all-zero burst completes with
//   min_index = 0 and min_value = all ones.
//   When undefined, 0 is an ordinary reading.
//
// Parameters:
//   WIDTH       - bit width of each reading
//   N_VALS      - readings per burst, 2..255
//   INDEX_WIDTH - width of min_index; 2**INDEX_WIDTH must exceed N_VALS
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle request to begin (or restart) a burst
//   value_in    in   reading, unsigned, WIDTH bits
//   value_valid in   value_in is consumed this cycle (only while collecting)
//   busy        out  high while collecting a burst
//   done        out  one-cycle pulse, result registers updated this cycle
//   min_value   out  smallest reading of the last completed burst
//   min_index   out  1-based position of min_value; 0 = no valid result
// ---------------------------------------------------------------------------
module find_min_n_vals_seq #(
    parameter int WIDTH       = 8,
    parameter int N_VALS      = 5,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       value_in,
    input  logic                   value_valid,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       min_value,
    output logic [INDEX_WIDTH-1:0] min_index
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LP_LAST = INDEX_WIDTH'(N_VALS - 1);

    state_t                 r_state;
    state_t                 w_next_state;

    logic [INDEX_WIDTH-1:0] r_count;
    logic [WIDTH-1:0]       r_work_min;
    logic [INDEX_WIDTH-1:0] r_work_idx;
    logic [WIDTH-1:0]       r_min_value;
    logic [INDEX_WIDTH-1:0] r_min_index;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_better;
    logic [WIDTH-1:0]       w_next_min;
    logic [INDEX_WIDTH-1:0] w_next_idx;

    // A start while collecting aborts the burst, so the reading presented in
    // that same cycle belongs to nobody and is dropped.
    assign w_accept = (r_state == S_COLLECT) && value_valid && !start;
    assign w_last   = w_accept && (r_count == LP_LAST);

`ifdef FIND_MIN_IGNORE_ZERO_EN
    // Zero readings never qualify; the first non-zero reading always does,
    // which is detected by the working index still being empty.
    assign w_better = (value_in != '0) &&
                      ((r_work_idx == '0) || (value_in < r_work_min));
`else
    // Strict less-than keeps the earliest position on ties.
    assign w_better = (r_count == '0) || (value_in < r_work_min);
`endif

    assign w_next_min = w_better ? value_in : r_work_min;
    assign w_next_idx = w_better ? INDEX_WIDTH'(r_count + 1'b1) : r_work_idx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches
    // on any path the case statement does not cover.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (start) begin
                    w_next_state = S_COLLECT;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = start ? S_COLLECT : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Working registers: start (from any state) reinitialises the burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_work_min <= '0;
            r_work_idx <= '0;
        end else if (start) begin
            r_count    <= '0;
            r_work_min <= '1;
            r_work_idx <= '0;
        end else if (w_accept) begin
            r_count    <= INDEX_WIDTH'(r_count + 1'b1);
            r_work_min <= w_next_min;
            r_work_idx <= w_next_idx;
        end
    end

    // Result registers load on the edge that accepts the final reading, so
    // the final reading is already folded in when done is seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_min_value <= '0;
            r_min_index <= '0;
        end else if (w_last) begin
            r_min_value <= w_next_min;
            r_min_index <= w_next_idx;
        end
    end

    assign busy      = (r_state == S_COLLECT);
    assign done      = (r_state == S_DONE);
    assign min_value = r_min_value;
    assign min_index = r_min_index;

endmodule

// File: tb/tb_find_min_n_vals_seq.sv
// ---------------------------------------------------------------------------
// tb_find_min_n_vals_seq
//
// Self-checking bench for find_min_n_vals_seq (WIDTH=8, N_VALS=5,
// INDEX_WIDTH=3). Expected results come from a small reference model and
// are queued when a burst is driven, then popped when done is observed.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_find_min_n_vals_seq;

    localparam int WIDTH       = 8;
    localparam int N_VALS      = 5;
    localparam int INDEX_WIDTH = 3;

    typedef logic [WIDTH-1:0] burst_t [N_VALS];
    typedef int               gaps_t  [N_VALS];

    typedef struct packed {
        logic [WIDTH-1:0]       min_value;
        logic [INDEX_WIDTH-1:0] min_index;
    } result_t;

    logic                   clock;
    logic                   reset;
    logic                   start;
    logic [WIDTH-1:0]       value_in;
    logic                   value_valid;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       min_value;
    logic [INDEX_WIDTH-1:0] min_index;

    int      n_vectors;
    int      n_miscompares;
    result_t scoreboard[$];
    result_t last_result;

    find_min_n_vals_seq #(
        .WIDTH       (WIDTH),
        .N_VALS      (N_VALS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .value_in    (value_in),
        .value_valid (value_valid),
        .busy        (busy),
        .done        (done),
        .min_value   (min_value),
        .min_index   (min_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: earliest strict minimum, 1-based index.
    function automatic result_t model(input burst_t v);
        result_t r;
        r.min_value = '1;
        r.min_index = '0;
        for (int i = 0; i < N_VALS; i++) begin
`ifdef FIND_MIN_IGNORE_ZERO_EN
            if (v[i] == '0) continue;
`endif
            if (r.min_index == '0 || v[i] < r.min_value) begin
                r.min_value = v[i];
                r.min_index = INDEX_WIDTH'(i + 1);
            end
        end
        return r;
    endfunction

    // Status word {busy, done, min_value, min_index} for compact compares.
    function automatic logic [WIDTH+INDEX_WIDTH+1:0] status();
        return {busy, done, min_value, min_index};
    endfunction

    // Drives one burst. skip_start: caller already issued start.
    // chain: raise start during the done cycle. rst_in_done: assert reset
    // while done is high and check the asynchronous clear.
    task automatic run_burst(input string name, input burst_t vals,
                             input gaps_t gaps, input bit skip_start,
                             input bit chain, input bit rst_in_done);
        result_t exp;
        result_t got;
        scoreboard.push_back(model(vals));
        if (!skip_start) begin
            // A valid reading beside start must not be consumed.
            start       = 1'b1;
            value_valid = 1'b1;
            value_in    = 8'h01;
            @(negedge clock);
            start       = 1'b0;
            value_valid = 1'b0;
        end
        for (int i = 0; i < N_VALS; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                value_valid = 1'b0;
                n_vectors++;
                if (status() !== {1'b1, 1'b0, last_result}) begin
                    n_miscompares++;
                    $display("FAIL %s gap %0d: status got %h expected %h",
                             name, i, status(), {1'b1, 1'b0, last_result});
                end
                @(negedge clock);
            end
            n_vectors++;
            if (status() !== {1'b1, 1'b0, last_result}) begin
                n_miscompares++;
                $display("FAIL %s value %0d: status got %h expected %h",
                         name, i, status(), {1'b1, 1'b0, last_result});
            end
            value_valid = 1'b1;
            value_in    = vals[i];
            @(negedge clock);
        end
        value_valid = 1'b0;
        // Result must be visible exactly one cycle after the last reading.
        n_vectors++;
        if ({busy, done} !== 2'b01) begin
            n_miscompares++;
            $display("FAIL %s done: busy/done got %b expected 01",
                     name, {busy, done});
        end
        exp = scoreboard.pop_front();
        got = '{min_value: min_value, min_index: min_index};
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s result: got value %0d index %0d expected value %0d index %0d",
                     name, got.min_value, got.min_index, exp.min_value, exp.min_index);
        end
        last_result = exp;
        if (rst_in_done) begin
            #2 reset = 1'b1;
            #1;
            n_vectors++;
            if (status() !== '0) begin
                n_miscompares++;
                $display("FAIL %s reset in done: status got %h expected 0",
                         name, status());
            end
            #1 reset = 1'b0;
            last_result = '0;
            @(negedge clock);
        end else if (chain) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            n_vectors++;
            if ({busy, done} !== 2'b10) begin
                n_miscompares++;
                $display("FAIL %s chained start: busy/done got %b expected 10",
                         name, {busy, done});
            end
        end else begin
            @(negedge clock);
            n_vectors++;
            if ({busy, done} !== 2'b00) begin
                n_miscompares++;
                $display("FAIL %s after done: busy/done got %b expected 00",
                         name, {busy, done});
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        start       = 1'b0;
        value_valid = 1'b0;
        value_in    = '0;
        last_result = '0;
        #2 reset = 1'b1;
        #1;
        n_vectors++;
        if (status() !== '0) begin
            n_miscompares++;
            $display("FAIL reset: status got %h expected 0", status());
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_vectors++;
        if (status() !== '0) begin
            n_miscompares++;
            $display("FAIL reset release: status got %h expected 0", status());
        end
    endtask

    task automatic test_patterns();
        gaps_t no_gaps = '{0, 0, 0, 0, 0};
        run_burst("ascending",  '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5},     no_gaps, 1'b0, 1'b1, 1'b0);
        run_burst("descending", '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1},     no_gaps, 1'b1, 1'b0, 1'b0);
        run_burst("middle",     '{8'd7, 8'd5, 8'd3, 8'd6, 8'd7},     no_gaps, 1'b0, 1'b0, 1'b0);
        run_burst("second",     '{8'd22, 8'd2, 8'd5, 8'd11, 8'd19},  no_gaps, 1'b0, 1'b0, 1'b0);
        run_burst("max_vals",   '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFF}, no_gaps, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        run_burst("gaps_tie", '{8'd9, 8'd8, 8'd2, 8'd2, 8'd3}, '{0, 2, 1, 3, 0},
                  1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        gaps_t no_gaps = '{0, 0, 0, 0, 0};
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            value_valid = 1'b1;
            value_in    = WIDTH'(4 + i);
            @(negedge clock);
            n_vectors++;
            if (status() !== {1'b1, 1'b0, last_result}) begin
                n_miscompares++;
                $display("FAIL abort partial %0d: status got %h expected %h",
                         i, status(), {1'b1, 1'b0, last_result});
            end
        end
        // Restart with a small reading that must be discarded.
        start       = 1'b1;
        value_valid = 1'b1;
        value_in    = 8'd1;
        @(negedge clock);
        start       = 1'b0;
        value_valid = 1'b0;
        run_burst("abort_restart", '{8'd9, 8'd8, 8'd7, 8'd2, 8'd3}, no_gaps,
                  1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_collect();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            value_valid = 1'b1;
            value_in    = WIDTH'(3 + i);
            @(negedge clock);
        end
        value_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_vectors++;
        if (status() !== '0) begin
            n_miscompares++;
            $display("FAIL reset in collect: status got %h expected 0", status());
        end
        #1 reset = 1'b0;
        last_result = '0;
        @(negedge clock);
        // Readings in IDLE must be ignored and done must never appear.
        for (int i = 0; i < 8; i++) begin
            value_valid = 1'b1;
            value_in    = WIDTH'(i);
            @(negedge clock);
            n_vectors++;
            if (status() !== '0) begin
                n_miscompares++;
                $display("FAIL idle ignores valid %0d: status got %h expected 0",
                         i, status());
            end
        end
        value_valid = 1'b0;
    endtask

    task automatic test_reset_done();
        gaps_t no_gaps = '{0, 0, 0, 0, 0};
        run_burst("reset_done", '{8'd30, 8'd20, 8'd10, 8'd40, 8'd50}, no_gaps,
                  1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero();
        gaps_t no_gaps = '{0, 0, 0, 0, 0};
        run_burst("zeros_mixed", '{8'd0, 8'd6, 8'd0, 8'd4, 8'd8}, no_gaps,
                  1'b0, 1'b0, 1'b0);
        run_burst("zeros_all",   '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, no_gaps,
                  1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        test_reset();
        test_patterns();
        test_gaps();
        test_abort();
        test_reset_collect();
        test_reset_done();
        test_zero();
        n_vectors++;
        if (scoreboard.size() != 0) begin
            n_miscompares++;
            $display("FAIL scoreboard drain: got %0d entries expected 0",
                     scoreboard.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/find_min_n_vals_seq.md
Name: find_min_n_vals_seq

Overview:
Sequential, parametrised successor to the combinational 5-input minimum finder. It accepts a burst of N_VALS unsigned readings, one per valid cycle (e.g. ultrasound ranges from successive sensor positions). It reports the smallest reading and its 1-based position in the burst, with a start/busy/done handshake. It sits between the range-sampling logic and the location/display logic of FPGA Phone Home.

Parameters:
- WIDTH, 8: bit width of each reading.
- N_VALS, 5: readings per burst; legal range 2..255.
- INDEX_WIDTH, 3: width of the index output; requires 2^INDEX_WIDTH > N_VALS.

Ports:
- clock, input, 1: system clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle request to begin a new burst.
- value_in, input, WIDTH: reading, unsigned.
- value_valid, input, 1: value_in is to be consumed this cycle.
- busy, output, 1: high while collecting a burst.
- done, output, 1: one-cycle pulse; result registers updated this cycle.
- min_value, output, WIDTH: smallest accepted reading of the last completed burst.
- min_index, output, INDEX_WIDTH: 1-based position of min_value in the burst; 0 = no valid result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, min_value=0, min_index=0; working count, working minimum and working index cleared.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - busy=0.
  - value_valid is ignored.
  - start -> COLLECT. On that edge: count=0, work_min=all ones, work_idx=0.
  - A value_valid in the same cycle as start is not consumed.
- COLLECT:
  - busy=1.
  - Each cycle with value_valid=1: count+1; if value_in < work_min (strict) or count==0, then work_min=value_in and work_idx=count+1.
  - On equal values, the earliest position wins.
  - When the N_VALS-th value is accepted -> DONE.
- COLLECT with start=1:
  - Burst aborts and restarts: count/work registers reinitialise, and value_valid that cycle is discarded.
  - Outputs keep the previous result; done is not pulsed for the aborted burst.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - min_value/min_index were loaded from the work registers, including the final value, on the entering edge.
  - Next state is IDLE, or COLLECT if start=1 (same initialisation as from IDLE).
- Latency: the N_VALS-th value is sampled on edge k; done and the result are visible in the cycle after edge k.
- Gaps in value_valid during COLLECT are allowed and do not time out.
- min_value/min_index hold until the next completed burst or reset.
- Comparison is unsigned WIDTH-bit.
- count is INDEX_WIDTH bits and never exceeds N_VALS.

Optional Feature:
- Macro: FIND_MIN_IGNORE_ZERO_EN.
- Defined:
  - A reading of 0 (no echo) still counts toward N_VALS but never becomes the minimum.
  - If every reading in the burst is 0, done still pulses with min_index=0 and min_value=all ones.
- Undefined: 0 is an ordinary reading and wins as the smallest value.

Test Plan:
- Reset, then start; feed 1,2,3,4,5 on consecutive cycles -> done one cycle after the last value, min_value=1, min_index=1, busy low during done.
- Burst 5,4,3,2,1 -> min_index=5, min_value=1. Burst 7,5,3,6,7 -> min_index=3, min_value=3. Burst 22,2,5,11,19 -> min_index=2, min_value=2.
- Burst 9,8,2,2,3 with value_valid gaps of 0-3 cycles between values -> min_index=3 (first tie wins), min_value=2; busy stays high throughout.
- Start mid-burst after 3 values, then feed 9,8,7,2,3 -> no done for the aborted burst; outputs keep the prior result until done; then min_index=4, min_value=2.
- Assert reset during COLLECT and during DONE -> all outputs 0 immediately (asynchronous); value_valid afterwards in IDLE has no effect; done never pulses without start.
- Burst 0,6,0,4,8 -> without macro: min_index=1, min_value=0; with FIND_MIN_IGNORE_ZERO_EN: min_index=4, min_value=4. All-zero burst with macro -> min_index=0, min_value=8'hFF.
